// File: rtl/oki_port_expander.sv
// oki_port_expander: 8243-style 4-bit port expander slave with glitch filter, direction tracking and RMW ops
module oki_port_expander #(
  parameter int NUM_PORTS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_n,
  input  logic [3:0]             p2_in,
  output logic [3:0]             p2_out,
  output logic                   p2_oe,
  output logic                   p2_buf_oe,
  output logic                   p2_buf_dir,
  input  logic [4*NUM_PORTS-1:0] port_in,
  output logic [4*NUM_PORTS-1:0] port_out,
  output logic [NUM_PORTS-1:0]   port_is_out,
  output logic [NUM_PORTS-1:0]   port_wr_stb,
  output logic [NUM_PORTS-1:0]   port_rd_stb
);
  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RD_DRIVE, TURN, WR_CAPT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] prog_sh;
  logic [4*SYNC_STAGES-1:0] p2_sh;
  logic prog_s, pf, edge_now, fall, rise, oe_q, pend;
  logic [3:0] p2_s, first_p2, cmd_now, cmd_q, idle_cmd, d_q, rd_val, wr_val, cur;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [NUM_PORTS-1:0] wr_pend;
  assign prog_s = prog_sh[SYNC_STAGES-1];
  assign p2_s = p2_sh[4*SYNC_STAGES-1 -: 4];
  assign edge_now = (prog_s != pf) && (cnt == CW'(FILT_CYCLES - 1));
  assign fall = edge_now & ~prog_s;
  assign rise = edge_now & prog_s;
  // the command is the p2 sample that accompanied the first low prog sample, not the one that confirmed the edge
  assign cmd_now = (cnt == '0) ? p2_s : first_p2;
  assign idle_cmd = pend ? cmd_q : cmd_now;
  assign p2_oe = oe_q & ~rst;
  assign p2_buf_oe = 1'b1;
  always_comb begin
    rd_val = 4'hF;
    cur = 4'h0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (idle_cmd[1:0] == 2'(i)) rd_val = port_is_out[i] ? port_out[4*i +: 4] : port_in[4*i +: 4];
      if (cmd_q[1:0] == 2'(i)) cur = port_out[4*i +: 4];
    end
    wr_val = cmd_q[3:2] == 2'b10 ? (cur | d_q) : cmd_q[3:2] == 2'b11 ? (cur & d_q) : d_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_sh <= '0;
      p2_sh <= '0;
      pf <= 1'b0;
      cnt <= '0;
      first_p2 <= '0;
      d_q <= '0;
      cmd_q <= '0;
      pend <= 1'b0;
      tcnt <= '0;
      state <= IDLE;
      port_out <= '0;
      port_is_out <= '0;
      port_wr_stb <= '0;
      port_rd_stb <= '0;
      wr_pend <= '0;
      p2_out <= '0;
      oe_q <= 1'b0;
      p2_buf_dir <= 1'b0;
    end else begin
      prog_sh <= {prog_sh[SYNC_STAGES-2:0], prog_n};
      p2_sh <= {p2_sh[4*SYNC_STAGES-5:0], p2_in};
      if (prog_s == pf) cnt <= '0;
      else if (edge_now) begin
        pf <= prog_s;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
      if (prog_s != pf && cnt == '0) first_p2 <= p2_s;
      if (!prog_s) d_q <= p2_s;
      port_rd_stb <= '0;
      port_wr_stb <= wr_pend;
      wr_pend <= '0;
      case (state)
        IDLE: if (fall || pend) begin
          pend <= 1'b0;
          cmd_q <= idle_cmd;
          if (idle_cmd[3:2] == 2'b00) begin
            p2_out <= rd_val;
            oe_q <= 1'b1;
            p2_buf_dir <= 1'b1;
            state <= RD_DRIVE;
            for (int i = 0; i < NUM_PORTS; i++)
              if (idle_cmd[1:0] == 2'(i)) begin
                port_is_out[i] <= 1'b0;
                port_rd_stb[i] <= 1'b1;
              end
          end else state <= WR_CAPT;
        end
        RD_DRIVE: if (rise) begin
          oe_q <= 1'b0;
          tcnt <= TW'(TURN_CYCLES - 1);
          state <= TURN;
        end
        TURN: begin
          if (fall) begin
            pend <= 1'b1;
            cmd_q <= cmd_now;
          end
          if (tcnt == '0) begin
            p2_buf_dir <= 1'b0;
            state <= IDLE;
          end else tcnt <= tcnt - 1'b1;
        end
        default: if (rise) begin
          for (int i = 0; i < NUM_PORTS; i++)
            if (cmd_q[1:0] == 2'(i)) begin
              port_out[4*i +: 4] <= wr_val;
              port_is_out[i] <= 1'b1;
              wr_pend[i] <= 1'b1;
            end
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_oki_port_expander.sv
// tb_oki_port_expander: scoreboard bench driving OKI bus strobes at minimum timing
`timescale 1ns/1ps
module tb_oki_port_expander;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prog_n = 1'b1;
  logic [3:0] p2_in = 4'h0;
  logic [3:0] p2_out;
  logic p2_oe, p2_buf_oe, p2_buf_dir;
  logic [15:0] port_in = 16'h73A5;
  logic [15:0] port_out;
  logic [3:0] port_is_out, port_wr_stb, port_rd_stb;
  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] m_out [4];
  logic [3:0] m_isout;
  logic [3:0] rd_q [$];
  logic [3:0] rdstb_q [$];
  logic [5:0] wr_q [$];
  logic oe_d = 1'b0;
  always #62.5 clk = ~clk;
  oki_port_expander dut (
    .clk(clk), .rst(rst), .prog_n(prog_n), .p2_in(p2_in), .p2_out(p2_out), .p2_oe(p2_oe),
    .p2_buf_oe(p2_buf_oe), .p2_buf_dir(p2_buf_dir), .port_in(port_in), .port_out(port_out),
    .port_is_out(port_is_out), .port_wr_stb(port_wr_stb), .port_rd_stb(port_rd_stb)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    oe_d <= p2_oe;
    if (p2_oe && !oe_d) begin
      if (rd_q.size() == 0) chk("unexpected p2_oe", 1, 0);
      else chk("p2_out", p2_out, rd_q.pop_front());
    end
    if (port_rd_stb != 0) begin
      if (rdstb_q.size() == 0) chk("unexpected rd_stb", port_rd_stb, 0);
      else chk("rd_stb", port_rd_stb, rdstb_q.pop_front());
    end
    if (port_wr_stb != 0) begin
      if (wr_q.size() == 0) chk("unexpected wr_stb", port_wr_stb, 0);
      else begin
        logic [5:0] e;
        e = wr_q.pop_front();
        chk("wr_stb", port_wr_stb, 4'b1 << e[5:4]);
        chk("port_out at wr_stb", port_out[4*e[5:4] +: 4], e[3:0]);
      end
    end
  end
  task automatic model(input logic [1:0] op, input logic [1:0] a, input logic [3:0] d);
    logic [3:0] v;
    if (op == 2'b00) begin
      rd_q.push_back(m_isout[a] ? m_out[a] : port_in[4*a +: 4]);
      rdstb_q.push_back(4'b1 << a);
      m_isout[a] = 1'b0;
    end else begin
      v = op == 2'b01 ? d : op == 2'b10 ? (m_out[a] | d) : (m_out[a] & d);
      m_out[a] = v;
      m_isout[a] = 1'b1;
      wr_q.push_back({a, v});
    end
  endtask
  // fall lands 55 ns before a sampling edge so the 60 ns command hold is honoured at 8 MHz
  task automatic xact(input logic [1:0] op, input logic [1:0] a, input logic [3:0] d);
    model(op, a, d);
    @(posedge clk);
    #20 p2_in = {op, a};
    #50 prog_n = 1'b0;
    #60 p2_in = d;
    #640 prog_n = 1'b1;
    #20 p2_in = ~d;
    #1500;
  endtask
  task automatic chk_regs(input string tag);
    chk({tag, " port_out"}, port_out, {m_out[3], m_out[2], m_out[1], m_out[0]});
    chk({tag, " port_is_out"}, port_is_out, m_isout);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
    m_isout = 4'h0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst p2_oe", p2_oe, 0);
    chk("rst p2_out", p2_out, 0);
    chk("rst buf_oe", p2_buf_oe, 1);
    chk("rst buf_dir", p2_buf_dir, 0);
    chk("rst strobes", {port_wr_stb, port_rd_stb}, 0);
    chk_regs("rst");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 3; i++) xact(2'b00, 2'(i), 4'h0);
    chk_regs("reads");
    xact(2'b01, 2'd3, 4'hF);
    xact(2'b11, 2'd3, 4'hD);
    chk("and port3", port_out[15:12], 4'hD);
    xact(2'b10, 2'd3, 4'h2);
    chk("or port3", port_out[15:12], 4'hF);
    chk_regs("rmw");
    xact(2'b01, 2'd1, 4'h9);
    xact(2'b00, 2'd1, 4'h0);
    chk("port1 input after read", port_is_out[1], 0);
    xact(2'b00, 2'd1, 4'h0);
    xact(2'b01, 2'd2, 4'hC);
    chk("min timing write", port_out[11:8], 4'hC);
    chk_regs("writes");
    @(posedge clk);
    #20 p2_in = 4'b0110;
    #50 prog_n = 1'b0;
    #100 prog_n = 1'b1;
    #1500;
    chk_regs("glitch");
    model(2'b00, 2'd0, 4'h0);
    @(posedge clk);
    #20 p2_in = 4'b0000;
    #50 prog_n = 1'b0;
    for (int i = 0; i < 20 && !p2_oe; i++) @(negedge clk);
    chk("rd drive before rst", p2_oe, 1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("p2_oe drops with rst", p2_oe, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
    m_isout = 4'h0;
    chk("mid rst buf_dir", p2_buf_dir, 0);
    chk("mid rst p2_out", p2_out, 0);
    chk_regs("mid rst");
    @(negedge clk) rst = 1'b0;
    #300 prog_n = 1'b1;
    #1500;
    chk("no oe after partial strobe", p2_oe, 0);
    xact(2'b00, 2'd0, 4'h0);
    xact(2'b00, 2'd2, 4'h0);
    chk_regs("after rst");
    chk("rd_q drained", rd_q.size(), 0);
    chk("rdstb_q drained", rdstb_q.size(), 0);
    chk("wr_q drained", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
